lc3_execute: RTL and testbench
==============================

LC3_EXECUTE -- requirements
Module: lc3_execute

Interface
REQ-001 The module SHALL have exactly one clock domain and use the following ports; the first two rows are the clock and reset.
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable_execute  in  1  stage advance; registers update only when 1
- E_Control  in  6  [5:4] alu_control, [3:2] pcselect1, [1] pcselect2, [0] op2select
- W_Control_in  in  2  writeback control from decode
- Mem_Control_in  in  1  memory control from decode
- IR  in  16  instruction from decode
- npc_in  in  16  next PC from decode
- VSR1  in  16  register-file value of source 1
- VSR2  in  16  register-file value of source 2
- bypass_alu_1  in  1  operand 1 takes previous aluout
- bypass_alu_2  in  1  operand 2 takes previous aluout
- bypass_mem_1  in  1  operand 1 takes Mem_Bypass_Val
- bypass_mem_2  in  1  operand 2 takes Mem_Bypass_Val
- Mem_Bypass_Val  in  16  value forwarded from memory stage
- aluout  out  16  registered ALU or address result
- pcout  out  16  registered effective address
- W_Control_out  out  2  registered W_Control_in
- Mem_Control_out  out  1  registered Mem_Control_in
- M_Data  out  16  registered store data
- dr  out  3  registered destination register
- NZP  out  3  registered branch condition mask
- IR_Exec  out  16  registered IR
- sr1  out  3  combinational IR[8:6]
- sr2  out  3  combinational: IR[2:0] for ALU opcodes, IR[11:9] for ST/STR/STI

Function
REQ-002 Operand 1 SHALL select, in priority order: aluout if bypass_alu_1; Mem_Bypass_Val if bypass_mem_1; otherwise VSR1. Operand 2 SHALL select the same way using bypass_alu_2, bypass_mem_2 and VSR2.
REQ-003 The ALU second input SHALL be operand 2 if op2select=1; otherwise sign-extended IR[4:0].
REQ-004 The ALU SHALL compute ADD for alu_control=00, AND for 01, NOT of operand 1 for 10, and pass operand 1 for 11, all modulo 2^16.
REQ-005 The address offset SHALL be selected by pcselect1: 00 sext(IR[10:0]), 01 sext(IR[8:0]), 10 sext(IR[5:0]), 11 0x0000.
REQ-006 The address base SHALL be npc_in if pcselect2=1, otherwise operand 1; address = base + offset mod 2^16.
REQ-007 On a rising clock with enable_execute=1, aluout SHALL load the ALU result when IR[15:12] is 0001, 0101 or 1001, and SHALL load the address otherwise.
REQ-008 On the same edge, pcout SHALL load the address, M_Data SHALL load operand 2, IR_Exec SHALL load IR, and W_Control_out and Mem_Control_out SHALL load their inputs.
REQ-009 On the same edge, dr SHALL load IR[11:9] for opcodes 0001, 0101, 1001, 0010, 0110, 1010 and 1110, and SHALL load 0 otherwise.
REQ-010 On the same edge, NZP SHALL load IR[11:9] for BR (0000), 111 for JMP (1100), and 000 otherwise.
REQ-011 When enable_execute=0, NZP SHALL clear to 000 on the next edge, and all other registered outputs SHALL hold their values.
REQ-012 Latency SHALL be one cycle from inputs to registered outputs.
REQ-013 Bypass on aluout SHALL use the value currently registered, giving back-to-back dependent ALU operations with no stall.

Reset
REQ-014 While reset=0, every registered output SHALL be 0 immediately, without waiting for a clock edge.
REQ-015 An IR that is in flight when reset asserts SHALL be discarded.
REQ-016 The first update after reset releases SHALL occur on the first rising edge that has enable_execute=1.

Verification
REQ-017 ADD register: IR=0x1283, VSR1=0x0005, VSR2=0x0007, E_Control=000001, enable=1 -> aluout=0x000C, dr=1, NZP=000.
REQ-018 ADD immediate: IR=0x103F, VSR1=0x0000, E_Control=000000 -> aluout=0xFFFF (wraps).
REQ-019 ALU bypass: follow REQ-017 with IR=0x1283, bypass_alu_2=1, VSR2=0x0099 -> aluout=0x0011.
REQ-020 Branch: IR=0x0E05, npc_in=0x3001, E_Control=000110 -> pcout=0x3006, aluout=0x3006, NZP=111; next cycle with enable=0 -> NZP=000, pcout still 0x3006.
REQ-021 Bypass priority: bypass_alu_1=1 and bypass_mem_1=1 together, aluout=0x0004, Mem_Bypass_Val=0x0100, pass op -> aluout=0x0004.
REQ-022 Mid-operation reset: assert reset=0 between edges -> all outputs 0 within the same cycle; release reset with enable=0 -> outputs stay 0.

Source files
------------

// File: rtl/lc3_execute.sv
// LC-3 pipeline execute stage: operand forwarding, ALU, effective-address adder
// and the execute/memory pipeline register.
module lc3_execute (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_execute,
  input  logic [5:0]  E_Control,
  input  logic [1:0]  W_Control_in,
  input  logic        Mem_Control_in,
  input  logic [15:0] IR,
  input  logic [15:0] npc_in,
  input  logic [15:0] VSR1,
  input  logic [15:0] VSR2,
  input  logic        bypass_alu_1,
  input  logic        bypass_alu_2,
  input  logic        bypass_mem_1,
  input  logic        bypass_mem_2,
  input  logic [15:0] Mem_Bypass_Val,
  output logic [15:0] aluout,
  output logic [15:0] pcout,
  output logic [1:0]  W_Control_out,
  output logic        Mem_Control_out,
  output logic [15:0] M_Data,
  output logic [2:0]  dr,
  output logic [2:0]  NZP,
  output logic [15:0] IR_Exec,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2
);

  logic [1:0]  alu_control;
  logic [1:0]  pcselect1;
  logic        pcselect2;
  logic        op2select;
  logic [3:0]  opcode;
  logic        is_alu_op;
  logic [15:0] op1, op2, alu_b, alu_res;
  logic [15:0] offset, base, addr;
  logic [2:0]  dr_next, nzp_next;

  assign alu_control = E_Control[5:4];
  assign pcselect1   = E_Control[3:2];
  assign pcselect2   = E_Control[1];
  assign op2select   = E_Control[0];
  assign opcode      = IR[15:12];
  assign is_alu_op   = (opcode == 4'b0001) || (opcode == 4'b0101) || (opcode == 4'b1001);

  assign sr1 = IR[8:6];
  // Stores read the data register through the second port.
  assign sr2 = ((opcode == 4'b0011) || (opcode == 4'b0111) || (opcode == 4'b1011)) ?
               IR[11:9] : IR[2:0];

  // Forwarding: the registered aluout has priority over the memory-stage value.
  always_comb begin
    if (bypass_alu_1)      op1 = aluout;
    else if (bypass_mem_1) op1 = Mem_Bypass_Val;
    else                   op1 = VSR1;
    if (bypass_alu_2)      op2 = aluout;
    else if (bypass_mem_2) op2 = Mem_Bypass_Val;
    else                   op2 = VSR2;
  end

  assign alu_b = op2select ? op2 : {{11{IR[4]}}, IR[4:0]};

  always_comb begin
    unique case (alu_control)
      2'b00:   alu_res = op1 + alu_b;
      2'b01:   alu_res = op1 & alu_b;
      2'b10:   alu_res = ~op1;
      default: alu_res = op1;
    endcase
  end

  always_comb begin
    unique case (pcselect1)
      2'b00:   offset = {{5{IR[10]}}, IR[10:0]};
      2'b01:   offset = {{7{IR[8]}}, IR[8:0]};
      2'b10:   offset = {{10{IR[5]}}, IR[5:0]};
      default: offset = 16'h0000;
    endcase
  end

  assign base = pcselect2 ? npc_in : op1;
  assign addr = base + offset;

  always_comb begin
    dr_next  = 3'b000;
    nzp_next = 3'b000;
    case (opcode)
      4'b0001, 4'b0101, 4'b1001, 4'b0010, 4'b0110, 4'b1010, 4'b1110: dr_next = IR[11:9];
      default: dr_next = 3'b000;
    endcase
    case (opcode)
      4'b0000: nzp_next = IR[11:9];
      4'b1100: nzp_next = 3'b111;
      default: nzp_next = 3'b000;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aluout          <= 16'h0000;
      pcout           <= 16'h0000;
      W_Control_out   <= 2'b00;
      Mem_Control_out <= 1'b0;
      M_Data          <= 16'h0000;
      dr              <= 3'b000;
      NZP             <= 3'b000;
      IR_Exec         <= 16'h0000;
    end else if (enable_execute) begin
      aluout          <= is_alu_op ? alu_res : addr;
      pcout           <= addr;
      W_Control_out   <= W_Control_in;
      Mem_Control_out <= Mem_Control_in;
      M_Data          <= op2;
      dr              <= dr_next;
      NZP             <= nzp_next;
      IR_Exec         <= IR;
    end else begin
      // A stalled stage must not leave a stale branch request behind.
      NZP <= 3'b000;
    end
  end

endmodule

// File: tb/tb_lc3_execute.sv
// Self-checking bench for lc3_execute: directed table, random vectors against an
// arithmetic reference model, and asynchronous-reset sequences.
module tb_lc3_execute;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_execute;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control_in;
  logic        Mem_Control_in;
  logic [15:0] IR, npc_in, VSR1, VSR2, Mem_Bypass_Val;
  logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [15:0] aluout, pcout, M_Data, IR_Exec;
  logic [1:0]  W_Control_out;
  logic        Mem_Control_out;
  logic [2:0]  dr, NZP, sr1, sr2;

  int n_cmp = 0;
  int n_err = 0;

  lc3_execute dut (
    .clock(clock), .reset(reset), .enable_execute(enable_execute), .E_Control(E_Control),
    .W_Control_in(W_Control_in), .Mem_Control_in(Mem_Control_in), .IR(IR), .npc_in(npc_in),
    .VSR1(VSR1), .VSR2(VSR2), .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2), .Mem_Bypass_Val(Mem_Bypass_Val),
    .aluout(aluout), .pcout(pcout), .W_Control_out(W_Control_out),
    .Mem_Control_out(Mem_Control_out), .M_Data(M_Data), .dr(dr), .NZP(NZP),
    .IR_Exec(IR_Exec), .sr1(sr1), .sr2(sr2)
  );

  always #5 clock = ~clock;

  // Reference model state (mirrors the registered outputs)
  int m_alu, m_pc, m_wc, m_mc, m_md, m_dr, m_nzp, m_ir;

  typedef struct {
    logic [15:0] ir, npc, vsr1, vsr2, mbv;
    logic [5:0]  ectl;
    logic [3:0]  byp;  // {alu_1, alu_2, mem_1, mem_2}
    logic        en;
    logic [15:0] e_alu, e_pc;
    logic [2:0]  e_nzp, e_dr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [15:0] ir, logic [15:0] npc, logic [15:0] vsr1,
                              logic [15:0] vsr2, logic [15:0] mbv, logic [5:0] ectl,
                              logic [3:0] byp, logic en, logic [15:0] e_alu,
                              logic [15:0] e_pc, logic [2:0] e_nzp, logic [2:0] e_dr);
    vec_t v;
    v.ir = ir; v.npc = npc; v.vsr1 = vsr1; v.vsr2 = vsr2; v.mbv = mbv; v.ectl = ectl;
    v.byp = byp; v.en = en; v.e_alu = e_alu; v.e_pc = e_pc; v.e_nzp = e_nzp; v.e_dr = e_dr;
    return v;
  endfunction

  function automatic int sext(int v, int bits);
    int x = v % (1 << bits);
    if (x >= (1 << (bits - 1))) x = x - (1 << bits);
    return x;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_alu = 0; m_pc = 0; m_wc = 0; m_mc = 0; m_md = 0; m_dr = 0; m_nzp = 0; m_ir = 0;
  endtask

  task automatic check_all(string tag);
    chk({tag, " aluout"}, int'(aluout), m_alu);
    chk({tag, " pcout"}, int'(pcout), m_pc);
    chk({tag, " W_Control_out"}, int'(W_Control_out), m_wc);
    chk({tag, " Mem_Control_out"}, int'(Mem_Control_out), m_mc);
    chk({tag, " M_Data"}, int'(M_Data), m_md);
    chk({tag, " dr"}, int'(dr), m_dr);
    chk({tag, " NZP"}, int'(NZP), m_nzp);
    chk({tag, " IR_Exec"}, int'(IR_Exec), m_ir);
  endtask

  task automatic drive(logic [15:0] ir, logic [15:0] npc, logic [15:0] vsr1, logic [15:0] vsr2,
                       logic [15:0] mbv, logic [5:0] ectl, logic [3:0] byp, logic en,
                       logic [1:0] wc, logic mc);
    IR = ir; npc_in = npc; VSR1 = vsr1; VSR2 = vsr2; Mem_Bypass_Val = mbv; E_Control = ectl;
    {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} = byp;
    enable_execute = en; W_Control_in = wc; Mem_Control_in = mc;
  endtask

  // Computes the stage result from the instruction-level rules, clocks once, compares.
  task automatic step_check(string tag);
    int op, a, b, bsel, res, off, base, addr, n_alu, n_dr, n_nzp, e_sr2;
    #1;
    op = int'(IR[15:12]);
    e_sr2 = (op == 3 || op == 7 || op == 11) ? int'(IR[11:9]) : int'(IR[2:0]);
    chk({tag, " sr1"}, int'(sr1), int'(IR[8:6]));
    chk({tag, " sr2"}, int'(sr2), e_sr2);
    a = bypass_alu_1 ? m_alu : bypass_mem_1 ? int'(Mem_Bypass_Val) : int'(VSR1);
    b = bypass_alu_2 ? m_alu : bypass_mem_2 ? int'(Mem_Bypass_Val) : int'(VSR2);
    bsel = E_Control[0] ? b : (sext(int'(IR), 5) & 16'hFFFF);
    case (E_Control[5:4])
      2'd0: res = (a + bsel) % 65536;
      2'd1: res = a & bsel;
      2'd2: res = 65535 - a;
      default: res = a;
    endcase
    case (E_Control[3:2])
      2'd0: off = sext(int'(IR), 11);
      2'd1: off = sext(int'(IR), 9);
      2'd2: off = sext(int'(IR), 6);
      default: off = 0;
    endcase
    base = E_Control[1] ? int'(npc_in) : a;
    addr = (base + off + 65536) % 65536;
    n_alu = (op == 1 || op == 5 || op == 9) ? res : addr;
    n_dr = (op inside {1, 5, 9, 2, 6, 10, 14}) ? int'(IR[11:9]) : 0;
    n_nzp = (op == 0) ? int'(IR[11:9]) : (op == 12) ? 7 : 0;
    @(posedge clock);
    #1;
    if (enable_execute) begin
      m_alu = n_alu; m_pc = addr; m_wc = int'(W_Control_in); m_mc = int'(Mem_Control_in);
      m_md = b; m_dr = n_dr; m_nzp = n_nzp; m_ir = int'(IR);
    end else begin
      m_nzp = 0;
    end
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0;
    drive(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 6'h0, 4'h0, 1'b0, 2'b0, 1'b0);
    model_reset();
    #2;
    check_all("reset_async");
    repeat (2) @(posedge clock);
    #1;
    // Release with enable low: nothing may load.
    reset = 1'b1;
    drive(16'h1283, 16'h3000, 16'h0005, 16'h0007, 16'h0, 6'b000001, 4'h0, 1'b0, 2'b11, 1'b1);
    step_check("post_reset_idle");

    tbl.push_back(mk(16'h1283, 16'h0000, 16'h0005, 16'h0007, 16'h0000, 6'b000001, 4'b0000, 1,
                     16'h000C, 16'h0288, 3'd0, 3'd1));
    tbl.push_back(mk(16'h1283, 16'h0000, 16'h0005, 16'h0099, 16'h0000, 6'b000001, 4'b0100, 1,
                     16'h0011, 16'h0288, 3'd0, 3'd1));
    tbl.push_back(mk(16'h103F, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 4'b0000, 1,
                     16'hFFFF, 16'h003F, 3'd0, 3'd0));
    tbl.push_back(mk(16'h0E05, 16'h3001, 16'h0000, 16'h0000, 16'h0000, 6'b000110, 4'b0000, 1,
                     16'h3006, 16'h3006, 3'd7, 3'd0));
    tbl.push_back(mk(16'h0E05, 16'h3001, 16'h0000, 16'h0000, 16'h0000, 6'b000110, 4'b0000, 0,
                     16'h3006, 16'h3006, 3'd0, 3'd0));
    tbl.push_back(mk(16'h1024, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 4'b0000, 1,
                     16'h0004, 16'h0024, 3'd0, 3'd0));
    tbl.push_back(mk(16'h1000, 16'h0000, 16'h7777, 16'h0000, 16'h0100, 6'b110000, 4'b1010, 1,
                     16'h0004, 16'h0004, 3'd0, 3'd0));
    tbl.push_back(mk(16'h5423, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 6'b010000, 4'b0000, 1,
                     16'h0003, 16'hFD22, 3'd0, 3'd2));
    tbl.push_back(mk(16'h967F, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 6'b100000, 4'b0010, 1,
                     16'hEDCB, 16'h10B3, 3'd0, 3'd3));
    tbl.push_back(mk(16'hC1C0, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 6'b001100, 4'b0000, 1,
                     16'h4000, 16'h4000, 3'd7, 3'd0));
    tbl.push_back(mk(16'h6A82, 16'h0000, 16'h2000, 16'h0000, 16'h0000, 6'b001000, 4'b0000, 1,
                     16'h2002, 16'h2002, 3'd0, 3'd5));
    tbl.push_back(mk(16'hEDFF, 16'h3000, 16'h0000, 16'h0000, 16'h0000, 6'b000110, 4'b0000, 1,
                     16'h2FFF, 16'h2FFF, 3'd0, 3'd6));
    tbl.push_back(mk(16'h3905, 16'h3000, 16'h0000, 16'hBEEF, 16'h0000, 6'b000110, 4'b0000, 1,
                     16'h2F05, 16'h2F05, 3'd0, 3'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ir, tbl[i].npc, tbl[i].vsr1, tbl[i].vsr2, tbl[i].mbv, tbl[i].ectl,
            tbl[i].byp, tbl[i].en, 2'(i), 1'(i));
      step_check($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl_aluout", i), int'(aluout), int'(tbl[i].e_alu));
      chk($sformatf("vec%0d tbl_pcout", i), int'(pcout), int'(tbl[i].e_pc));
      chk($sformatf("vec%0d tbl_NZP", i), int'(NZP), int'(tbl[i].e_nzp));
      chk($sformatf("vec%0d tbl_dr", i), int'(dr), int'(tbl[i].e_dr));
    end

    for (int i = 0; i < 300; i++) begin
      drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            6'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0), 2'($urandom),
            1'($urandom));
      step_check($sformatf("rnd%0d", i));
    end

    // Reset between edges clears everything at once; the in-flight IR is dropped.
    drive(16'h1283, 16'h1111, 16'h0005, 16'h0007, 16'h0, 6'b000001, 4'h0, 1'b1, 2'b11, 1'b1);
    step_check("pre_reset");
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset");
    enable_execute = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    step_check("release_en0");
    drive(16'h0E05, 16'h3001, 16'h0, 16'h0, 16'h0, 6'b000110, 4'h0, 1'b1, 2'b01, 1'b0);
    step_check("first_update");
    chk("first_update pcout_const", int'(pcout), 16'h3006);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
